ps2_cmd_sequencer: RTL

Host-side command controller for the PS/2 port. It sequences the existing byte sender and byte reader so the keyboard/mouse can be sent a command, with an optional argument byte (e.g. 0xED + LED mask). For each byte it waits for the device ACK (0xFA), handles resend (0xFE) and timeouts with bounded retries, and reports done or error. It sits between the top level and the sender/reader pair, and forwards unsolicited received bytes as scan codes.

---
 rtl/ps2_cmd_sequencer_pkg.sv | 14 +
 rtl/ps2_timeout_cnt.sv | 24 ++
 rtl/ps2_cmd_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_cmd_sequencer_pkg.sv
// Shared PS/2 protocol constants for the host command sequencer.
// The FSM state encoding is kept local to the sequencer.
package ps2_cmd_sequencer_pkg;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR  = 8'hFC;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_RESEND  = 2'd2;
  localparam logic [1:0] ERR_DEVICE  = 2'd3;

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Per-byte timeout counter: cleared when a byte is launched, counts while
// waiting, and flags the last allowed cycle of the wait.
module ps2_timeout_cnt #(
  parameter int ACK_TIMEOUT = 2000000,
  parameter int CNT_W       = 21
) (
  input  logic ck,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge ck or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign hit = en && (cnt == CNT_W'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// Host-side PS/2 command sequencer: sends a command (plus optional argument),
// waits for ACK with resend/timeout retries, and forwards unsolicited bytes.
module ps2_cmd_sequencer
  import ps2_cmd_sequencer_pkg::*;
#(
  parameter int ACK_TIMEOUT = 2000000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 21
) (
  input  logic       ck,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] arg_byte,
  output logic       tx_send,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_active,
  output logic       busy_read,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       scan_valid,
  output logic [7:0] scan_data
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, WAIT_BUS, SEND, WAIT_TX, WAIT_ACK, DONE, ERR
  } state_t;

  state_t          state, state_n;
  logic [7:0]      cmd_q, cmd_n, arg_q, arg_n;
  logic            has_arg_q, has_arg_n;
  logic            cur_arg, cur_arg_n;
  logic [RW-1:0]   retry, retry_n;
  logic [1:0]      code_q, code_n;
  logic            tx_seen, tx_seen_n;
  logic            fwd;
  logic            tmr_clr, tmr_en, tmr_hit;
  logic            can_retry;

  ps2_timeout_cnt #(.ACK_TIMEOUT(ACK_TIMEOUT), .CNT_W(CNT_W)) u_tmo (
    .ck    (ck),
    .reset (reset),
    .clear (tmr_clr),
    .en    (tmr_en),
    .hit   (tmr_hit)
  );

  assign can_retry = (retry < RMAX);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_q      <= '0;
      arg_q      <= '0;
      has_arg_q  <= 1'b0;
      cur_arg    <= 1'b0;
      retry      <= '0;
      code_q     <= ERR_NONE;
      tx_seen    <= 1'b0;
      scan_valid <= 1'b0;
      scan_data  <= '0;
    end else begin
      state      <= state_n;
      cmd_q      <= cmd_n;
      arg_q      <= arg_n;
      has_arg_q  <= has_arg_n;
      cur_arg    <= cur_arg_n;
      retry      <= retry_n;
      code_q     <= code_n;
      tx_seen    <= tx_seen_n;
      scan_valid <= fwd;
      if (fwd) scan_data <= rx_data;
    end
  end

  always_comb begin
    state_n   = state;
    cmd_n     = cmd_q;
    arg_n     = arg_q;
    has_arg_n = has_arg_q;
    cur_arg_n = cur_arg;
    retry_n   = retry;
    code_n    = code_q;
    tx_seen_n = tx_seen;
    fwd       = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        fwd = rx_ready;
        if (cmd_valid) begin
          cmd_n     = cmd_byte;
          arg_n     = arg_byte;
          has_arg_n = cmd_has_arg;
          cur_arg_n = 1'b0;
          retry_n   = '0;
          state_n   = WAIT_BUS;
        end
      end
      WAIT_BUS: begin
        fwd = rx_ready;
        if (!rx_active && !tx_busy) state_n = SEND;
      end
      SEND: begin
        fwd       = rx_ready;
        tmr_clr   = 1'b1;
        tx_seen_n = 1'b0;
        state_n   = WAIT_TX;
      end
      // Host owns the bus here, so any received byte is spurious and dropped.
      WAIT_TX: begin
        tmr_en = 1'b1;
        if (tx_busy) tx_seen_n = 1'b1;
        if (tx_seen && !tx_busy) state_n = WAIT_ACK;
        else if (tmr_hit) begin
          if (can_retry) begin
            retry_n = retry + 1'b1;
            state_n = WAIT_BUS;
          end else begin
            code_n  = ERR_TIMEOUT;
            state_n = ERR;
          end
        end
      end
      // A received byte takes priority over a timeout landing on the same cycle.
      WAIT_ACK: begin
        tmr_en = 1'b1;
        if (rx_ready) begin
          case (rx_data)
            PS2_ACK: begin
              if (!cur_arg && has_arg_q) begin
                cur_arg_n = 1'b1;
                retry_n   = '0;
                state_n   = WAIT_BUS;
              end else begin
                state_n = DONE;
              end
            end
            PS2_RESEND: begin
              if (can_retry) begin
                retry_n = retry + 1'b1;
                state_n = WAIT_BUS;
              end else begin
                code_n  = ERR_RESEND;
                state_n = ERR;
              end
            end
            PS2_ERROR: begin
              code_n  = ERR_DEVICE;
              state_n = ERR;
            end
            default: fwd = 1'b1;
          endcase
        end else if (tmr_hit) begin
          if (can_retry) begin
            retry_n = retry + 1'b1;
            state_n = WAIT_BUS;
          end else begin
            code_n  = ERR_TIMEOUT;
            state_n = ERR;
          end
        end
      end
      DONE: begin
        fwd     = rx_ready;
        state_n = IDLE;
      end
      ERR: begin
        fwd     = rx_ready;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign tx_send   = (state == SEND);
  assign tx_data   = cur_arg ? arg_q : cmd_q;
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign err_code  = (state == ERR) ? code_q : ERR_NONE;
  assign busy_read = rx_active;

endmodule
